// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side bundle of the uart_tx round-robin arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold req/data until their ack pulse.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8,
  parameter int GW   = 2
);
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] din_bus;
  logic [NREQ-1:0]      ack;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick;
  logic                 busy;
  logic [GW-1:0]        grant_id;
  logic                 timeout_err;
  logic                 err_clr;

  // Producers, transmitter feedback and error clear drive the arbiter.
  modport master (
    output req, din_bus, tx_done_tick, err_clr,
    input  ack, tx_start, tx_din, busy, grant_id, timeout_err
  );

  // The arbiter itself.
  modport slave (
    input  req, din_bus, tx_done_tick, err_clr,
    output ack, tx_start, tx_din, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte producers.
// Latency: req seen in IDLE -> tx_start/ack registered on the next edge.
// Backpressure: one frame in flight; requests stay unacked during BUSY/GAP.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DBIT        = 8,
  parameter int GW          = 2,
  parameter int GAP_CYC     = 0,
  parameter int TIMEOUT_CYC = 65536
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One counter serves both the BUSY watchdog and the GAP delay.
  localparam int CMAX = ((TIMEOUT_CYC - 1) > GAP_CYC) ? (TIMEOUT_CYC - 1) : GAP_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_q;
  logic [CW-1:0]   cnt_q;
  logic            tx_start_q;
  logic [NREQ-1:0] ack_q;
  logic [DBIT-1:0] tx_din_q;
  logic [GW-1:0]   grant_id_q;
  logic            busy_q;
  logic            timeout_err_q;

  logic            gnt_vld_d;
  logic [PW-1:0]   gnt_d;
  logic [DBIT-1:0] din_d;
  logic [PW-1:0]   rr_d;

  // Round-robin pick: first pass covers rr_q..NREQ-1, second pass wraps to 0.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    din_d     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld_d && bus.req[i] && (PW'(i) >= rr_q)) begin
        gnt_vld_d = 1'b1;
        gnt_d     = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld_d && bus.req[i]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == gnt_d) begin
        din_d = bus.din_bus[i*DBIT +: DBIT];
      end
    end
    rr_d = (gnt_d == PTR_LAST) ? '0 : gnt_d + 1'b1;
  end

  // Frame FSM: grant in IDLE, wait for done or watchdog in BUSY, idle out in GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      cnt_q         <= '0;
      tx_start_q    <= 1'b0;
      ack_q         <= '0;
      tx_din_q      <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      // A watchdog set below in the same cycle overrides this clear.
      if (bus.err_clr) begin
        timeout_err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            tx_din_q   <= din_d;
            grant_id_q <= GW'(gnt_d);
            tx_start_q <= 1'b1;
            for (int i = 0; i < NREQ; i++) begin
              ack_q[i] <= (PW'(i) == gnt_d);
            end
            rr_q    <= rr_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.tx_done_tick) begin
            cnt_q <= '0;
            if (GAP_CYC == 0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            // Frame lost: flag it and release the transmitter.
            timeout_err_q <= 1'b1;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.ack         = ack_q;
  assign bus.tx_din      = tx_din_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
